// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multiport register file.
package regfile_pkg;

    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefAddrW = 3;

    typedef enum logic {
        WrPortA = 1'b0,
        WrPortB = 1'b1
    } wr_port_e;

    // When both ports hit the same register, this port's data is kept.
    localparam wr_port_e WrWinner = WrPortB;

    // Lowest bit of element idx in a flattened vector of width-bit elements.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: load issue sets, port-B write-back clears.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned DEPTH   = 1 << ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic                     iss_stall,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [DEPTH-1:0]         busy_vec
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    assign iss_stall = iss_en & busy_q[iss_addr];
    assign busy_vec  = busy_q;

    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
        end
        // Set after clear: a new load to a register being written back stays pending.
        if (iss_en && !iss_stall) begin
            busy_d[iss_addr] = 1'b1;
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_busy[i] = busy_q[rd_addr[slice_lo(i, ADDR_W) +: ADDR_W]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file: NUM_RD read ports, two write ports, busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned DEPTH   = 1 << ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_stall,
    output logic [DEPTH-1:0]         busy_vec,
    output logic                     wr_conflict,
    output logic [DEPTH*DATA_W-1:0]  dbg_regs
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              wr_conflict_q;
    logic              wr_conflict_d;

    // Winner/loser view of the two write ports.
    logic              win_en,   lose_en;
    logic [ADDR_W-1:0] win_addr, lose_addr;
    logic [DATA_W-1:0] win_data, lose_data;

    always_comb begin
        if (WrWinner == WrPortB) begin
            win_en  = wb_en;  win_addr  = wb_addr;  win_data  = wb_data;
            lose_en = wa_en;  lose_addr = wa_addr;  lose_data = wa_data;
        end else begin
            win_en  = wa_en;  win_addr  = wa_addr;  win_data  = wa_data;
            lose_en = wb_en;  lose_addr = wb_addr;  lose_data = wb_data;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (lose_en) begin
            regs_d[lose_addr] = lose_data;
        end
        if (win_en) begin
            regs_d[win_addr] = win_data;
        end
        if (ZERO_REG) begin
            regs_d[0] = '0;
        end
    end

    assign wr_conflict_d = wa_en & wb_en & (wa_addr == wb_addr);
    assign wr_conflict   = wr_conflict_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                regs_q[k] <= '0;
            end
            wr_conflict_q <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] val;

        assign addr = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];

        always_comb begin
`ifdef REGFILE_BYPASS_EN
            if (win_en && win_addr == addr) begin
                val = win_data;
            end else if (lose_en && lose_addr == addr) begin
                val = lose_data;
            end else begin
                val = regs_q[addr];
            end
`else
            val = regs_q[addr];
`endif
            // Also blocks forwarding of writes aimed at the hardwired zero.
            if (ZERO_REG && addr == '0) begin
                val = '0;
            end
        end

        assign rd_data[slice_lo(i, DATA_W) +: DATA_W] = val;
    end

    for (genvar j = 0; j < DEPTH; j++) begin : g_dbg
        assign dbg_regs[slice_lo(j, DATA_W) +: DATA_W] = regs_q[j];
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .rd_addr   (rd_addr),
        .iss_stall (iss_stall),
        .rd_busy   (rd_busy),
        .busy_vec  (busy_vec)
    );

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench for regfile_multiport (default 8x16, two read ports).
module tb_regfile_multiport;

    logic        clk;
    logic        rst;
    logic        wa_en;
    logic [2:0]  wa_addr;
    logic [15:0] wa_data;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  rd_busy;
    logic        iss_en;
    logic [2:0]  iss_addr;
    logic        iss_stall;
    logic [7:0]  busy_vec;
    logic        wr_conflict;
    logic [127:0] dbg_regs;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_multiport dut (
        .clk         (clk),
        .rst         (rst),
        .wa_en       (wa_en),
        .wa_addr     (wa_addr),
        .wa_data     (wa_data),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .iss_en      (iss_en),
        .iss_addr    (iss_addr),
        .iss_stall   (iss_stall),
        .busy_vec    (busy_vec),
        .wr_conflict (wr_conflict),
        .dbg_regs    (dbg_regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] dreg(input int k);
        return dbg_regs[k*16 +: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wa_en  = 1'b0;
        wb_en  = 1'b0;
        iss_en = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (dbg_regs !== '0) begin n_fail++; $display("FAIL rst_regs got %h exp 0", dbg_regs); end
        n_checks++; if (busy_vec !== 8'h00) begin n_fail++; $display("FAIL rst_busy got %h exp 00", busy_vec); end
        n_checks++; if (wr_conflict !== 1'b0) begin n_fail++; $display("FAIL rst_conf got %b exp 0", wr_conflict); end
        wa_en = 1'b1; wa_addr = 3'd3; wa_data = 16'h1234;
        iss_en = 1'b1; iss_addr = 3'd1;
        tick();
        idle();
        n_checks++; if (dreg(3) !== 16'h1234) begin n_fail++; $display("FAIL pre_rst_r3 got %h exp 1234", dreg(3)); end
        n_checks++; if (busy_vec !== 8'h02) begin n_fail++; $display("FAIL pre_rst_busy got %h exp 02", busy_vec); end
        wa_en = 1'b1; wa_addr = 3'd7; wa_data = 16'h1111;
        wb_en = 1'b1; wb_addr = 3'd7; wb_data = 16'h2222;
        tick();
        idle();
        n_checks++; if (wr_conflict !== 1'b1) begin n_fail++; $display("FAIL pre_rst_conf got %b exp 1", wr_conflict); end
        rst = 1'b1;
        #1;
        n_checks++; if (dbg_regs !== '0) begin n_fail++; $display("FAIL async_rst_regs got %h exp 0", dbg_regs); end
        n_checks++; if (busy_vec !== 8'h00) begin n_fail++; $display("FAIL async_rst_busy got %h exp 00", busy_vec); end
        n_checks++; if (wr_conflict !== 1'b0) begin n_fail++; $display("FAIL async_rst_conf got %b exp 0", wr_conflict); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_collision();
        wa_en = 1'b1; wa_addr = 3'd5; wa_data = 16'hAAAA;
        wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h5555;
        tick();
        idle();
        n_checks++; if (dreg(5) !== 16'h5555) begin n_fail++; $display("FAIL coll_r5 got %h exp 5555", dreg(5)); end
        n_checks++; if (wr_conflict !== 1'b1) begin n_fail++; $display("FAIL coll_pulse got %b exp 1", wr_conflict); end
        tick();
        n_checks++; if (wr_conflict !== 1'b0) begin n_fail++; $display("FAIL coll_end got %b exp 0", wr_conflict); end
        // Different addresses on both ports: no conflict, both stored.
        wa_en = 1'b1; wa_addr = 3'd6; wa_data = 16'h0101;
        wb_en = 1'b1; wb_addr = 3'd7; wb_data = 16'h0202;
        tick();
        idle();
        n_checks++; if (wr_conflict !== 1'b0) begin n_fail++; $display("FAIL nocoll_conf got %b exp 0", wr_conflict); end
        n_checks++; if ({dreg(6), dreg(7)} !== 32'h0101_0202) begin
            n_fail++; $display("FAIL nocoll_data got %h exp 01010202", {dreg(6), dreg(7)});
        end
    endtask

    task automatic test_zero_reg();
        wa_en = 1'b1; wa_addr = 3'd0; wa_data = 16'hFFFF;
        wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'hFFFF;
        iss_en = 1'b1; iss_addr = 3'd0;
        rd_addr = {3'd5, 3'd0};
        #1;
        n_checks++; if (iss_stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall got %b exp 0", iss_stall); end
        n_checks++; if (rd_data[15:0] !== 16'h0000) begin n_fail++; $display("FAIL zero_rd_now got %h exp 0000", rd_data[15:0]); end
        tick();
        idle();
        n_checks++; if (dreg(0) !== 16'h0000) begin n_fail++; $display("FAIL zero_r0 got %h exp 0000", dreg(0)); end
        n_checks++; if (rd_data[15:0] !== 16'h0000) begin n_fail++; $display("FAIL zero_rd got %h exp 0000", rd_data[15:0]); end
        n_checks++; if (busy_vec[0] !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %b exp 0", busy_vec[0]); end
        n_checks++; if (wr_conflict !== 1'b1) begin n_fail++; $display("FAIL zero_conf got %b exp 1", wr_conflict); end
        n_checks++; if (rd_data[31:16] !== 16'h5555) begin n_fail++; $display("FAIL zero_rd_p1 got %h exp 5555", rd_data[31:16]); end
        tick();
    endtask

    task automatic test_scoreboard();
        rd_addr = {3'd5, 3'd2};
        iss_en = 1'b1; iss_addr = 3'd2;
        #1;
        n_checks++; if (iss_stall !== 1'b0) begin n_fail++; $display("FAIL sb_first_stall got %b exp 0", iss_stall); end
        tick();
        idle();
        n_checks++; if (busy_vec !== 8'h04) begin n_fail++; $display("FAIL sb_busy got %h exp 04", busy_vec); end
        n_checks++; if (rd_busy !== 2'b01) begin n_fail++; $display("FAIL sb_rd_busy got %b exp 01", rd_busy); end
        // Re-issue stalls; a port-A write to the busy register leaves busy alone.
        iss_en = 1'b1; iss_addr = 3'd2;
        wa_en = 1'b1; wa_addr = 3'd2; wa_data = 16'h7777;
        #1;
        n_checks++; if (iss_stall !== 1'b1) begin n_fail++; $display("FAIL sb_stall got %b exp 1", iss_stall); end
        tick();
        wa_en = 1'b0;
        n_checks++; if (busy_vec !== 8'h04) begin n_fail++; $display("FAIL sb_stall_busy got %h exp 04", busy_vec); end
        // Write-back while the requester still holds the issue.
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h00C3;
        #1;
        n_checks++; if (iss_stall !== 1'b1) begin n_fail++; $display("FAIL sb_wb_stall got %b exp 1", iss_stall); end
        tick();
        wb_en = 1'b0;
        #1;
        n_checks++; if (busy_vec !== 8'h00) begin n_fail++; $display("FAIL sb_clear got %h exp 00", busy_vec); end
        n_checks++; if (iss_stall !== 1'b0) begin n_fail++; $display("FAIL sb_release got %b exp 0", iss_stall); end
        n_checks++; if (rd_data[15:0] !== 16'h00C3) begin n_fail++; $display("FAIL sb_r2 got %h exp 00c3", rd_data[15:0]); end
        idle();
        tick();
    endtask

    task automatic test_issue_wb_same();
        iss_en = 1'b1; iss_addr = 3'd6;
        wb_en = 1'b1; wb_addr = 3'd6; wb_data = 16'h0BEE;
        tick();
        idle();
        n_checks++; if (busy_vec !== 8'h40) begin n_fail++; $display("FAIL iwb_busy got %h exp 40", busy_vec); end
        n_checks++; if (dreg(6) !== 16'h0BEE) begin n_fail++; $display("FAIL iwb_r6 got %h exp 0bee", dreg(6)); end
        wb_en = 1'b1; wb_addr = 3'd6; wb_data = 16'h0BEF;
        tick();
        idle();
        n_checks++; if (busy_vec !== 8'h00) begin n_fail++; $display("FAIL iwb_clear got %h exp 00", busy_vec); end
    endtask

    task automatic test_bypass();
        logic [15:0] exp_same;
        rd_addr = {3'd4, 3'd0};
        wa_en = 1'b1; wa_addr = 3'd4; wa_data = 16'h0F0F;
`ifdef REGFILE_BYPASS_EN
        exp_same = 16'h0F0F;
`else
        exp_same = 16'h0000;
`endif
        #1;
        n_checks++; if (rd_data[31:16] !== exp_same) begin n_fail++; $display("FAIL byp_same got %h exp %h", rd_data[31:16], exp_same); end
        tick();
        idle();
        n_checks++; if (rd_data[31:16] !== 16'h0F0F) begin n_fail++; $display("FAIL byp_next got %h exp 0f0f", rd_data[31:16]); end
        // Both ports on r4 (B wins) and a write to r0 that must never forward.
        wa_en = 1'b1; wa_addr = 3'd4; wa_data = 16'h1111;
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h2222;
`ifdef REGFILE_BYPASS_EN
        exp_same = 16'h2222;
`else
        exp_same = 16'h0F0F;
`endif
        #1;
        n_checks++; if (rd_data[31:16] !== exp_same) begin n_fail++; $display("FAIL byp_prio got %h exp %h", rd_data[31:16], exp_same); end
        tick();
        wa_addr = 3'd0; wa_data = 16'hFFFF; wb_en = 1'b0;
        #1;
        n_checks++; if (rd_data[15:0] !== 16'h0000) begin n_fail++; $display("FAIL byp_r0 got %h exp 0000", rd_data[15:0]); end
        n_checks++; if (rd_data[31:16] !== 16'h2222) begin n_fail++; $display("FAIL byp_stored got %h exp 2222", rd_data[31:16]); end
        tick();
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        wa_addr = '0; wa_data = '0;
        wb_addr = '0; wb_data = '0;
        iss_addr = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        test_reset();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_issue_wb_same();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
